hvf_ref_gen: RTL

- Reference timing generator for 1080i 20-bit video. Produces the H/V/F reference bus that the line-alignment logic consumes, plus pixel and line counters.
- Free-runs on the reference clock. Can genlock to an external frame-start pulse, with lock-loss detection.
- Sits upstream of every consumer of the reference HVF bus; one instance serves the whole design.

---
 rtl/hvf_ref_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hvf_ref_gen.sv
// 1080i reference H/V/F timing generator with genlock to an external frame-start pulse.
// Optional TRS word output enabled by defining HVF_REF_GEN_TRS_EN.
module hvf_ref_gen #(
  parameter int unsigned H_ACTIVE     = 1920,
  parameter int unsigned H_TOTAL      = 2200,
  parameter int unsigned V_TOTAL      = 1125,
  parameter int unsigned F1_ACT_START = 20,
  parameter int unsigned F1_ACT_END   = 560,
  parameter int unsigned F2_START     = 562,
  parameter int unsigned F2_ACT_START = 583,
  parameter int unsigned F2_ACT_END   = 1123,
  parameter int unsigned MISS_LIMIT   = 3
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        lock_en,
  input  logic        ext_frame_sync,
  output logic [2:0]  HVF_ref_out,
  output logic [11:0] pix_cnt,
  output logic [10:0] line_cnt,
  output logic        locked,
  output logic        frame_start
`ifdef HVF_REF_GEN_TRS_EN
  ,
  output logic [19:0] trs_out
`endif
);

  typedef enum logic [1:0] {FREE_RUN, SEARCH, LOCKED} state_t;

  localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0] HT_M1_C  = 12'(H_TOTAL - 1);
  localparam logic [10:0] VT_M1_C  = 11'(V_TOTAL - 1);
  localparam logic [10:0] F1_AS_C  = 11'(F1_ACT_START);
  localparam logic [10:0] F1_AE_C  = 11'(F1_ACT_END);
  localparam logic [10:0] F2_S_C   = 11'(F2_START);
  localparam logic [10:0] F2_AS_C  = 11'(F2_ACT_START);
  localparam logic [10:0] F2_AE_C  = 11'(F2_ACT_END);
  localparam logic [1:0]  MISS_LIM_C = 2'(MISS_LIMIT);

  state_t      state;
  logic [1:0]  miss_cnt;
  logic        bad_frame;

  logic        wrap;
  logic        jump;
  logic [11:0] pix_nxt;
  logic [10:0] line_nxt;
  logic        h_nxt;
  logic        v_nxt;
  logic        f_nxt;
  logic [1:0]  miss_inc;

  // Outputs are decoded from the next counter values so they register alongside the counters.
  always_comb begin
    wrap     = (pix_cnt == HT_M1_C) && (line_cnt == VT_M1_C);
    jump     = (state == SEARCH) && lock_en && ext_frame_sync;
    pix_nxt  = '0;
    line_nxt = '0;
    if (!jump) begin
      if (pix_cnt == HT_M1_C) begin
        pix_nxt  = '0;
        line_nxt = (line_cnt == VT_M1_C) ? '0 : line_cnt + 11'd1;
      end else begin
        pix_nxt  = pix_cnt + 12'd1;
        line_nxt = line_cnt;
      end
    end
    h_nxt    = (pix_nxt >= H_ACT_C);
    v_nxt    = !(((line_nxt >= F1_AS_C) && (line_nxt < F1_AE_C)) ||
                 ((line_nxt >= F2_AS_C) && (line_nxt < F2_AE_C)));
    f_nxt    = (line_nxt >= F2_S_C);
    miss_inc = (miss_cnt == 2'd3) ? miss_cnt : miss_cnt + 2'd1;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      HVF_ref_out <= 3'b010;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      state       <= FREE_RUN;
      miss_cnt    <= '0;
      bad_frame   <= 1'b0;
    end else begin
      pix_cnt     <= pix_nxt;
      line_cnt    <= line_nxt;
      HVF_ref_out <= {f_nxt, v_nxt, h_nxt};
      frame_start <= (pix_nxt == '0) && (line_nxt == '0);
      case (state)
        FREE_RUN: begin
          if (lock_en) state <= SEARCH;
        end
        SEARCH: begin
          if (!lock_en) begin
            state <= FREE_RUN;
          end else if (ext_frame_sync) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            miss_cnt  <= '0;
            bad_frame <= 1'b0;
          end
        end
        LOCKED: begin
          if (!lock_en) begin
            state     <= FREE_RUN;
            locked    <= 1'b0;
            miss_cnt  <= '0;
            bad_frame <= 1'b0;
          end else if (wrap) begin
            // A mistimed pulse earlier in the frame still counts as a miss even if the wrap pulse is good.
            bad_frame <= 1'b0;
            if (bad_frame || !ext_frame_sync) begin
              if (miss_inc >= MISS_LIM_C) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end else begin
              miss_cnt <= '0;
            end
          end else if (ext_frame_sync) begin
            bad_frame <= 1'b1;
          end
        end
        default: begin
          state  <= FREE_RUN;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef HVF_REF_GEN_TRS_EN
  localparam logic [11:0] SAV_C = 12'(H_TOTAL - 4);

  logic [9:0]  xyz_eav;
  logic [9:0]  xyz_sav;
  logic [19:0] trs_nxt;

  always_comb begin
    xyz_eav = {1'b1, f_nxt, v_nxt, h_nxt, v_nxt ^ h_nxt, f_nxt ^ h_nxt,
               f_nxt ^ v_nxt, f_nxt ^ v_nxt ^ h_nxt, 2'b00};
    xyz_sav = {1'b1, f_nxt, v_nxt, 1'b0, v_nxt, f_nxt, f_nxt ^ v_nxt, f_nxt ^ v_nxt, 2'b00};
    trs_nxt = {10'h040, 10'h200};
    if (pix_nxt == H_ACT_C || pix_nxt == SAV_C) begin
      trs_nxt = '1;
    end else if (pix_nxt == H_ACT_C + 12'd1 || pix_nxt == H_ACT_C + 12'd2 ||
                 pix_nxt == SAV_C + 12'd1   || pix_nxt == SAV_C + 12'd2) begin
      trs_nxt = '0;
    end else if (pix_nxt == H_ACT_C + 12'd3) begin
      trs_nxt = {xyz_eav, xyz_eav};
    end else if (pix_nxt == HT_M1_C) begin
      trs_nxt = {xyz_sav, xyz_sav};
    end else if (!h_nxt && !v_nxt) begin
      trs_nxt = '0;
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) trs_out <= {10'h040, 10'h200};
    else        trs_out <= trs_nxt;
  end
`endif

endmodule
